// File: rtl/proj_job_scheduler.sv
// rtl/proj_job_scheduler.sv - sequences the six QKV projection jobs onto the shared matmul engine
// Optional WAIT-state watchdog enabled by defining SCHED_TIMEOUT_EN.

module proj_job_scheduler #(
   parameter int                ADDR_W      = 12,
   parameter logic [ADDR_W-1:0] INPUT_BASE  = 12'h000,
   parameter logic [ADDR_W-1:0] W_BASE      = 12'h180,
   parameter logic [ADDR_W-1:0] W_STRIDE    = 12'h240,
   parameter int                TIMEOUT_CYC = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [5:0]        job_mask,
   input  logic              status_clr,
   output logic              eng_req_valid,
   input  logic              eng_req_ready,
   output logic [ADDR_W-1:0] eng_in_base,
   output logic [ADDR_W-1:0] eng_w_base,
   output logic [2:0]        eng_job_id,
   input  logic              eng_done,
   input  logic              eng_err,
   output logic              busy,
   output logic              done,
   output logic [7:0]        status
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_ISSUE  = 3'd2,
      S_WAIT   = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [5:0]        pend;
   logic [2:0]        job_id;
   logic [2:0]        sel_id;
   logic [ADDR_W-1:0] in_base_q;
   logic [ADDR_W-1:0] w_base_q;
   logic [ADDR_W-1:0] w_calc;
   logic [2:0]        count;
   logic              done_sticky;
   logic              start_overrun;
   logic              timeout_err;
   logic              eng_err_sticky;
   logic              timeout;
   logic              job_end;

   // Lowest pending job wins; scanning downward leaves the lowest set bit last.
   always_comb begin
      sel_id = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (pend[i]) sel_id = 3'(i);
      end
   end

   assign w_calc  = W_BASE + ADDR_W'(sel_id) * W_STRIDE;
   assign job_end = (state == S_WAIT) && eng_done;

`ifdef SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (rst || state != S_WAIT) tmo_cnt <= '0;
      else                        tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign timeout = (state == S_WAIT) && !eng_done && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_SELECT;
         S_SELECT: state_nxt = (pend == 6'd0) ? S_FINISH : S_ISSUE;
         S_ISSUE:  if (eng_req_ready) state_nxt = S_WAIT;
         S_WAIT:   if (eng_done || timeout) state_nxt = S_SELECT;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         pend           <= 6'd0;
         job_id         <= 3'd0;
         in_base_q      <= '0;
         w_base_q       <= '0;
         count          <= 3'd0;
         done_sticky    <= 1'b0;
         start_overrun  <= 1'b0;
         timeout_err    <= 1'b0;
         eng_err_sticky <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (start) begin
                  pend        <= job_mask;
                  count       <= 3'd0;
                  done_sticky <= 1'b0;
               end
            end
            S_SELECT: begin
               if (pend != 6'd0) begin
                  job_id    <= sel_id;
                  w_base_q  <= w_calc;
                  in_base_q <= INPUT_BASE;
               end
            end
            S_WAIT: begin
               if (eng_done) begin
                  pend <= eng_err ? 6'd0 : (pend & ~(6'd1 << job_id));
                  if (count != 3'd6) count <= count + 3'd1;
               end else if (timeout) begin
                  pend <= 6'd0;
               end
            end
            S_FINISH: done_sticky <= 1'b1;
            default: ;
         endcase
         // A same-cycle event takes precedence over status_clr.
         start_overrun  <= (start && state != S_IDLE) || (start_overrun && !status_clr);
         timeout_err    <= timeout || (timeout_err && !status_clr);
         eng_err_sticky <= (job_end && eng_err) || (eng_err_sticky && !status_clr);
      end
   end

   assign eng_req_valid = (state == S_ISSUE) && !rst;
   assign eng_in_base   = in_base_q;
   assign eng_w_base    = w_base_q;
   assign eng_job_id    = job_id;
   assign busy          = (state == S_SELECT) || (state == S_ISSUE) || (state == S_WAIT);
   assign done          = (state == S_FINISH);
   assign status        = {eng_err_sticky, timeout_err, start_overrun, done_sticky, busy, count};

endmodule

// File: tb/tb_proj_job_scheduler.sv
// tb/tb_proj_job_scheduler.sv - directed self-checking bench for proj_job_scheduler

module tb_proj_job_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  job_mask = 6'd0;
   logic        status_clr = 1'b0;
   logic        eng_req_valid;
   logic        eng_req_ready = 1'b0;
   logic [11:0] eng_in_base;
   logic [11:0] eng_w_base;
   logic [2:0]  eng_job_id;
   logic        eng_done = 1'b0;
   logic        eng_err = 1'b0;
   logic        busy;
   logic        done;
   logic [7:0]  status;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   proj_job_scheduler #(
      .ADDR_W(12), .INPUT_BASE(12'h000), .W_BASE(12'h180), .W_STRIDE(12'h240), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .job_mask(job_mask), .status_clr(status_clr),
      .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready),
      .eng_in_base(eng_in_base), .eng_w_base(eng_w_base), .eng_job_id(eng_job_id),
      .eng_done(eng_done), .eng_err(eng_err), .busy(busy), .done(done), .status(status)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // engine model configuration (written by tests) and logs (written by the model)
   logic eng_en = 1'b0;
   int   ready_hold = 0;
   int   done_delay = 10;
   int   err_at = -1;
   int   n_req = 0;
   int   unstable = 0;
   int   req_id[8];
   int   req_wb[8];
   int   req_ib[8];
   int   req_cyc[8];
   int   eng_done_cyc[8];
   int   e_st = 0;
   int   hold_cnt = 0;
   int   dcnt = 0;
   logic [11:0] snap_wb;
   logic [11:0] snap_ib;
   logic [2:0]  snap_id;
   int   done_cnt = 0;
   int   done_cyc = 0;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   always @(negedge clk) begin
      eng_req_ready = 1'b0;
      eng_done = 1'b0;
      eng_err = 1'b0;
      if (!eng_en) begin
         e_st = 0; hold_cnt = 0; n_req = 0; unstable = 0;
      end else if (e_st == 0) begin
         if (eng_req_valid === 1'b1) begin
            if (hold_cnt == 0) begin
               snap_wb = eng_w_base; snap_ib = eng_in_base; snap_id = eng_job_id;
               if (n_req < 8) req_cyc[n_req] = cyc;
            end else if (eng_w_base !== snap_wb || eng_in_base !== snap_ib || eng_job_id !== snap_id) begin
               unstable = unstable + 1;
            end
            if (hold_cnt < ready_hold) begin
               hold_cnt = hold_cnt + 1;
            end else begin
               eng_req_ready = 1'b1;
               if (n_req < 8) begin
                  req_id[n_req] = int'(eng_job_id);
                  req_wb[n_req] = int'(eng_w_base);
                  req_ib[n_req] = int'(eng_in_base);
               end
               n_req = n_req + 1;
               e_st = 1; dcnt = 0; hold_cnt = 0;
            end
         end else if (hold_cnt > 0) begin
            unstable = unstable + 1;
         end
      end else begin
         dcnt = dcnt + 1;
         if (dcnt == done_delay) begin
            eng_done = 1'b1;
            eng_err = (n_req - 1 == err_at);
            if (n_req >= 1 && n_req <= 8) eng_done_cyc[n_req-1] = cyc;
            e_st = 0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic engine_setup(input int hold, input int ddel, input int errj);
      eng_en = 1'b0;
      tick(); tick();
      ready_hold = hold; done_delay = ddel; err_at = errj;
      eng_en = 1'b1;
      tick();
   endtask

   task automatic pulse_start(input logic [5:0] m, output int t0);
      job_mask = m; start = 1'b1; t0 = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt != d0) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick(); tick();
      tests_run++; if (eng_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", eng_req_valid); end
      tests_run++; if (eng_w_base !== 12'h000 || eng_in_base !== 12'h000 || eng_job_id !== 3'd0) begin
         tests_failed++; $display("FAIL reset_addr got w=%h in=%h id=%0d want 0", eng_w_base, eng_in_base, eng_job_id); end
      tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
      tests_run++; if (status !== 8'h00) begin tests_failed++; $display("FAIL reset_status got %h want 00", status); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_all_jobs();
      int t0, d0;
      bit ok;
      int exp_wb[6] = '{12'h180, 12'h3C0, 12'h600, 12'h840, 12'hA80, 12'hCC0};
      engine_setup(0, 10, -1);
      d0 = done_cnt;
      pulse_start(6'h3F, t0);
      wait_done(d0, 400, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL all_done_timeout got no done want done"); end
      tests_run++; if (n_req != 6) begin tests_failed++; $display("FAIL all_nreq got %0d want 6", n_req); end
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (req_id[i] != i || req_wb[i] != exp_wb[i] || req_ib[i] != 0) begin
            tests_failed++; $display("FAIL all_req%0d got id=%0d w=%h in=%h want id=%0d w=%h in=0", i, req_id[i], req_wb[i], req_ib[i], i, exp_wb[i]);
         end
      end
      tests_run++; if (req_cyc[0] != t0 + 2) begin tests_failed++; $display("FAIL all_first_latency got %0d want %0d", req_cyc[0], t0 + 2); end
      tests_run++; if (req_cyc[1] != eng_done_cyc[0] + 2) begin tests_failed++; $display("FAIL all_next_latency got %0d want %0d", req_cyc[1], eng_done_cyc[0] + 2); end
      tick();
      tests_run++; if (status !== 8'h16) begin tests_failed++; $display("FAIL all_status got %h want 16", status); end
      tests_run++; if (done_cnt != d0 + 1) begin tests_failed++; $display("FAIL all_done_count got %0d want %0d", done_cnt - d0, 1); end
   endtask

   task automatic test_sparse_mask();
      int t0, d0;
      bit ok;
      engine_setup(0, 4, -1);
      d0 = done_cnt;
      pulse_start(6'b100100, t0);
      wait_done(d0, 200, ok);
      tick();
      tests_run++; if (!ok || n_req != 2) begin tests_failed++; $display("FAIL sparse_nreq got %0d done=%0d want 2 done=1", n_req, ok); end
      tests_run++; if (req_id[0] != 2 || req_wb[0] != 12'h600 || req_id[1] != 5 || req_wb[1] != 12'hCC0) begin
         tests_failed++; $display("FAIL sparse_reqs got %0d/%h %0d/%h want 2/600 5/cc0", req_id[0], req_wb[0], req_id[1], req_wb[1]); end
      tests_run++; if (status[2:0] !== 3'd2) begin tests_failed++; $display("FAIL sparse_count got %0d want 2", status[2:0]); end
   endtask

   task automatic test_empty_mask();
      int t0, d0;
      engine_setup(0, 4, -1);
      d0 = done_cnt;
      pulse_start(6'd0, t0);
      tests_run++; if (busy !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL empty_t1 got busy=%b done=%b want 1 0", busy, done); end
      tick();
      tests_run++; if (done !== 1'b1 || busy !== 1'b0 || cyc != t0 + 2) begin
         tests_failed++; $display("FAIL empty_t2 got done=%b busy=%b cyc=%0d want 1 0 %0d", done, busy, cyc, t0 + 2); end
      tick(); tick();
      tests_run++; if (n_req != 0 || status[2:0] !== 3'd0 || done_cnt != d0 + 1) begin
         tests_failed++; $display("FAIL empty_result got nreq=%0d cnt=%0d dones=%0d want 0 0 1", n_req, status[2:0], done_cnt - d0); end
   endtask

   task automatic test_backpressure_overrun();
      int t0, t1, d0;
      bit ok;
      engine_setup(5, 10, -1);
      d0 = done_cnt;
      pulse_start(6'h3F, t0);
      for (int i = 0; i < 50 && n_req < 1; i++) tick();
      tick(); tick(); tick();
      pulse_start(6'h01, t1);
      wait_done(d0, 600, ok);
      tick();
      tests_run++; if (!ok || n_req != 6) begin tests_failed++; $display("FAIL bp_nreq got %0d done=%0d want 6 done=1", n_req, ok); end
      tests_run++; if (unstable != 0) begin tests_failed++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
      tests_run++; if (req_id[1] != 1 || req_id[5] != 5) begin tests_failed++; $display("FAIL bp_order got %0d,%0d want 1,5", req_id[1], req_id[5]); end
      tests_run++; if (status[5] !== 1'b1) begin tests_failed++; $display("FAIL bp_overrun got %b want 1", status[5]); end
   endtask

   task automatic test_eng_err();
      int t0, d0;
      bit ok;
      engine_setup(0, 3, 1);
      d0 = done_cnt;
      pulse_start(6'h3F, t0);
      wait_done(d0, 300, ok);
      tick(); tick(); tick();
      tests_run++; if (!ok || n_req != 2) begin tests_failed++; $display("FAIL err_nreq got %0d done=%0d want 2 done=1", n_req, ok); end
      tests_run++; if (status[7] !== 1'b1 || status[2:0] !== 3'd2) begin
         tests_failed++; $display("FAIL err_status got %h want bit7=1 count=2", status); end
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
      tests_run++; if (status !== 8'h12) begin tests_failed++; $display("FAIL err_clr got %h want 12", status); end
   endtask

   task automatic test_reset_mid_job();
      int t0, d0;
      engine_setup(0, 10, -1);
      d0 = done_cnt;
      pulse_start(6'h3F, t0);
      for (int i = 0; i < 200 && n_req < 4; i++) tick();
      tick(); tick();
      tests_run++; if (busy !== 1'b1 || eng_job_id !== 3'd3) begin tests_failed++; $display("FAIL rst_pre got busy=%b id=%0d want 1 3", busy, eng_job_id); end
      rst = 1'b1;
      eng_en = 1'b0;
      tick();
      tests_run++; if (eng_req_valid !== 1'b0 || eng_w_base !== 12'h0 || eng_in_base !== 12'h0 || eng_job_id !== 3'd0) begin
         tests_failed++; $display("FAIL rst_mid_eng got v=%b w=%h in=%h id=%0d want 0", eng_req_valid, eng_w_base, eng_in_base, eng_job_id); end
      tests_run++; if (busy !== 1'b0 || done !== 1'b0 || status !== 8'h00) begin
         tests_failed++; $display("FAIL rst_mid_status got busy=%b done=%b st=%h want 0 0 00", busy, done, status); end
      rst = 1'b0;
      tick(); tick();
      tests_run++; if (done_cnt != d0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_no_done got dones=%0d busy=%b want 0 0", done_cnt - d0, busy); end
   endtask

`ifdef SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int t0, d0;
      bit ok;
      engine_setup(0, 1000, -1);
      d0 = done_cnt;
      pulse_start(6'h01, t0);
      wait_done(d0, 100, ok);
      tests_run++; if (!ok || done_cyc != req_cyc[0] + 18) begin
         tests_failed++; $display("FAIL tmo_done got ok=%0d cyc=%0d want 1 %0d", ok, done_cyc, req_cyc[0] + 18); end
      tick();
      tests_run++; if (status[6] !== 1'b1 || status[2:0] !== 3'd0) begin tests_failed++; $display("FAIL tmo_status got %h want bit6=1 count=0", status); end
      eng_en = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_all_jobs();
      test_sparse_mask();
      test_empty_mask();
      test_backpressure_overrun();
      test_eng_err();
      test_reset_mid_job();
`ifdef SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
